// File: rtl/rf_writeback_arbiter.sv
// Merges the in-order pipeline writeback (A) and a buffered long-latency result stream (B)
// onto the register file's single write port, and tracks pending destinations for decode.
module rf_writeback_arbiter #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 32,
  parameter int unsigned AW    = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       a_valid,
  input  logic [AW-1:0]              a_reg,
  input  logic [DW-1:0]              a_data,
  input  logic                       b_valid,
  output logic                       b_ready,
  input  logic [AW-1:0]              b_reg,
  input  logic [DW-1:0]              b_data,
  input  logic                       iss_valid,
  input  logic [AW-1:0]              iss_reg,
  output logic                       rf_w,
  output logic [AW-1:0]              rf_wreg,
  output logic [DW-1:0]              rf_wdata,
  output logic [(1<<AW)-1:0]         pend,
  output logic [$clog2(DEPTH):0]     fifo_cnt,
  output logic                       waw_err
);

  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CW   = PW + 1;
  localparam int unsigned NREG = 1 << AW;

  logic [AW-1:0]   mem_reg_q  [DEPTH];
  logic [DW-1:0]   mem_data_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rf_w_q, rf_w_d;
  logic [AW-1:0]   rf_wreg_q, rf_wreg_d;
  logic [DW-1:0]   rf_wdata_q, rf_wdata_d;
  logic [NREG-1:0] pend_q, pend_d;
  logic            waw_q, waw_d;

  logic a_wr, b_acc, fifo_ne, push, pop;

  assign b_ready = (cnt_q != CW'(DEPTH));

  // Write-port selection, FIFO bookkeeping, scoreboard and WAW diagnostic
  always_comb begin
    rf_w_d     = 1'b0;
    rf_wreg_d  = rf_wreg_q;
    rf_wdata_d = rf_wdata_q;
    pop        = 1'b0;
    push       = 1'b0;
    a_wr       = a_valid && (a_reg != '0);
    b_acc      = b_valid && b_ready;
    fifo_ne    = (cnt_q != '0);

    if (a_wr) begin
      rf_w_d     = 1'b1;
      rf_wreg_d  = a_reg;
      rf_wdata_d = a_data;
    end else if (fifo_ne) begin
      rf_w_d     = 1'b1;
      rf_wreg_d  = mem_reg_q[rd_ptr_q];
      rf_wdata_d = mem_data_q[rd_ptr_q];
      pop        = 1'b1;
    end else if (b_acc && (b_reg != '0)) begin
      rf_w_d     = 1'b1;
      rf_wreg_d  = b_reg;
      rf_wdata_d = b_data;
    end

    // b_acc already implies not full, so a full FIFO never takes a push
    push = b_acc && (b_reg != '0) && (a_wr || fifo_ne);

    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    cnt_d    = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CW'(1);
    else if (pop && !push) cnt_d = cnt_q - CW'(1);

    // Clear on the commit happening at this edge; a same-cycle issue wins
    pend_d = pend_q;
    if (rf_w_q)    pend_d[rf_wreg_q] = 1'b0;
    if (iss_valid) pend_d[iss_reg]   = 1'b1;
    pend_d[0] = 1'b0;

    waw_d = waw_q;
    if (iss_valid && (iss_reg != '0) && pend_q[iss_reg] &&
        !(rf_w_q && (rf_wreg_q == iss_reg)))
      waw_d = 1'b1;
    if (a_valid && (a_reg != '0) && pend_q[a_reg])
      waw_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      rf_w_q     <= 1'b0;
      rf_wreg_q  <= '0;
      rf_wdata_q <= '0;
      pend_q     <= '0;
      waw_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      rf_w_q     <= rf_w_d;
      rf_wreg_q  <= rf_wreg_d;
      rf_wdata_q <= rf_wdata_d;
      pend_q     <= pend_d;
      waw_q      <= waw_d;
    end
  end

  // Payload storage needs no reset; occupancy is governed by the pointers
  always_ff @(posedge clk) begin
    if (push) begin
      mem_reg_q[wr_ptr_q]  <= b_reg;
      mem_data_q[wr_ptr_q] <= b_data;
    end
  end

  assign rf_w     = rf_w_q;
  assign rf_wreg  = rf_wreg_q;
  assign rf_wdata = rf_wdata_q;
  assign pend     = pend_q;
  assign fifo_cnt = cnt_q;
  assign waw_err  = waw_q;

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed bench for rf_writeback_arbiter: priority, bypass, FIFO fill/drain, reg0, reset, WAW.
module tb_rf_writeback_arbiter;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_valid, b_valid, iss_valid;
  logic [AW-1:0] a_reg, b_reg, iss_reg;
  logic [DW-1:0] a_data, b_data;
  logic          b_ready, rf_w, waw_err;
  logic [AW-1:0] rf_wreg;
  logic [DW-1:0] rf_wdata;
  logic [31:0]   pend;
  logic [2:0]    fifo_cnt;

  int checks = 0;
  int errors = 0;

  rf_writeback_arbiter #(.DEPTH(DEPTH), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
    .iss_valid(iss_valid), .iss_reg(iss_reg),
    .rf_w(rf_w), .rf_wreg(rf_wreg), .rf_wdata(rf_wdata),
    .pend(pend), .fifo_cnt(fifo_cnt), .waw_err(waw_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 0; a_reg = '0; a_data = '0;
    b_valid = 0; b_reg = '0; b_data = '0;
    iss_valid = 0; iss_reg = '0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    #12;
    checks++;
    if ({rf_w, rf_wreg, rf_wdata} !== {1'b0, 5'd0, 32'd0}) begin
      errors++; $display("FAIL reset_rf: got w=%0b reg=%0d data=%h, need 0/0/0", rf_w, rf_wreg, rf_wdata);
    end
    checks++;
    if (pend !== 32'd0 || fifo_cnt !== 3'd0 || waw_err !== 1'b0 || b_ready !== 1'b1) begin
      errors++; $display("FAIL reset_state: got pend=%h cnt=%0d waw=%0b rdy=%0b, need 0/0/0/1", pend, fifo_cnt, waw_err, b_ready);
    end
    rst_n = 1;
    step();
  endtask

  task automatic test_a_path();
    a_valid = 1; a_reg = 5'd3; a_data = 32'h11;
    step();
    a_valid = 0;
    checks++;
    if ({rf_w, rf_wreg, rf_wdata} !== {1'b1, 5'd3, 32'h11}) begin
      errors++; $display("FAIL a_write: got w=%0b reg=%0d data=%h, need 1/3/11", rf_w, rf_wreg, rf_wdata);
    end
    step();
    checks++;
    if ({rf_w, rf_wreg, rf_wdata} !== {1'b0, 5'd3, 32'h11}) begin
      errors++; $display("FAIL a_idle_hold: got w=%0b reg=%0d data=%h, need 0/3/11", rf_w, rf_wreg, rf_wdata);
    end
  endtask

  task automatic test_bypass_scoreboard();
    iss_valid = 1; iss_reg = 5'd5;
    step();
    iss_valid = 0;
    checks++;
    if (pend !== 32'h20) begin
      errors++; $display("FAIL pend_set: got %h, need 00000020", pend);
    end
    step(); step();
    b_valid = 1; b_reg = 5'd5; b_data = 32'hAB;
    checks++;
    if (b_ready !== 1'b1) begin
      errors++; $display("FAIL bypass_ready: got %0b, need 1", b_ready);
    end
    step();
    b_valid = 0;
    checks++;
    if ({rf_w, rf_wreg, rf_wdata, fifo_cnt} !== {1'b1, 5'd5, 32'hAB, 3'd0} || pend !== 32'h20) begin
      errors++; $display("FAIL bypass_write: got w=%0b reg=%0d data=%h cnt=%0d pend=%h, need 1/5/ab/0/20",
                         rf_w, rf_wreg, rf_wdata, fifo_cnt, pend);
    end
    step();
    checks++;
    if (pend !== 32'd0 || rf_w !== 1'b0 || waw_err !== 1'b0) begin
      errors++; $display("FAIL pend_clear: got pend=%h w=%0b waw=%0b, need 0/0/0", pend, rf_w, waw_err);
    end
  endtask

  task automatic test_conflict();
    a_valid = 1; a_reg = 5'd2; a_data = 32'h22;
    b_valid = 1; b_reg = 5'd7; b_data = 32'h77;
    step();
    idle_inputs();
    checks++;
    if ({rf_w, rf_wreg, rf_wdata, fifo_cnt} !== {1'b1, 5'd2, 32'h22, 3'd1}) begin
      errors++; $display("FAIL conflict_a: got w=%0b reg=%0d data=%h cnt=%0d, need 1/2/22/1", rf_w, rf_wreg, rf_wdata, fifo_cnt);
    end
    step();
    checks++;
    if ({rf_w, rf_wreg, rf_wdata, fifo_cnt} !== {1'b1, 5'd7, 32'h77, 3'd0}) begin
      errors++; $display("FAIL conflict_b: got w=%0b reg=%0d data=%h cnt=%0d, need 1/7/77/0", rf_w, rf_wreg, rf_wdata, fifo_cnt);
    end
    step();
    checks++;
    if (rf_w !== 1'b0) begin
      errors++; $display("FAIL conflict_idle: got w=%0b, need 0", rf_w);
    end
  endtask

  task automatic test_full_fifo();
    int  nextb;
    logic rdy;
    nextb = 1;
    for (int i = 0; i < 6; i++) begin
      a_valid = 1; a_reg = AW'(10 + i); a_data = 32'h100 + 32'(i);
      b_valid = 1; b_reg = 5'd20; b_data = 32'(nextb);
      rdy = b_ready;
      checks++;
      if (rdy !== (i < 4)) begin
        errors++; $display("FAIL full_ready[%0d]: got %0b, need %0b", i, rdy, (i < 4));
      end
      step();
      if (rdy) nextb++;
      checks++;
      if ({rf_w, rf_wreg, fifo_cnt} !== {1'b1, AW'(10 + i), 3'((i < 3) ? i + 1 : 4)}) begin
        errors++; $display("FAIL full_fill[%0d]: got w=%0b reg=%0d cnt=%0d, need 1/%0d/%0d",
                           i, rf_w, rf_wreg, fifo_cnt, 10 + i, (i < 3) ? i + 1 : 4);
      end
    end
    idle_inputs();
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++;
      if ({rf_w, rf_wreg, rf_wdata, fifo_cnt, b_ready} !== {1'b1, 5'd20, 32'(k), 3'(4 - k), 1'b1}) begin
        errors++; $display("FAIL drain[%0d]: got w=%0b reg=%0d data=%h cnt=%0d rdy=%0b, need 1/20/%0h/%0d/1",
                           k, rf_w, rf_wreg, rf_wdata, fifo_cnt, b_ready, k, 4 - k);
      end
    end
    step();
    checks++;
    if (rf_w !== 1'b0) begin
      errors++; $display("FAIL drain_done: got w=%0b, need 0", rf_w);
    end
  endtask

  task automatic test_reg0();
    a_valid = 1; a_reg = 5'd0; a_data = 32'hFF;
    step();
    a_valid = 0;
    checks++;
    if (rf_w !== 1'b0 || rf_wdata !== 32'd4) begin
      errors++; $display("FAIL reg0_a: got w=%0b data=%h, need 0/4", rf_w, rf_wdata);
    end
    b_valid = 1; b_reg = 5'd0; b_data = 32'h55;
    checks++;
    if (b_ready !== 1'b1) begin
      errors++; $display("FAIL reg0_b_ready: got %0b, need 1", b_ready);
    end
    step();
    b_valid = 0;
    checks++;
    if (rf_w !== 1'b0 || fifo_cnt !== 3'd0 || waw_err !== 1'b0) begin
      errors++; $display("FAIL reg0_b: got w=%0b cnt=%0d waw=%0b, need 0/0/0", rf_w, fifo_cnt, waw_err);
    end
  endtask

  task automatic test_reset_mid_op();
    for (int i = 0; i < 3; i++) begin
      a_valid = 1; a_reg = AW'(1 + i); a_data = 32'(i);
      b_valid = 1; b_reg = 5'd12; b_data = 32'h40 + 32'(i);
      iss_valid = (i < 2); iss_reg = (i == 0) ? 5'd5 : 5'd7;
      step();
    end
    checks++;
    if (fifo_cnt !== 3'd3 || pend !== 32'hA0) begin
      errors++; $display("FAIL pre_reset: got cnt=%0d pend=%h, need 3/000000a0", fifo_cnt, pend);
    end
    idle_inputs();
    #2 rst_n = 0;
    #1;
    checks++;
    if (rf_w !== 1'b0 || pend !== 32'd0 || fifo_cnt !== 3'd0 || b_ready !== 1'b1) begin
      errors++; $display("FAIL mid_reset: got w=%0b pend=%h cnt=%0d rdy=%0b, need 0/0/0/1", rf_w, pend, fifo_cnt, b_ready);
    end
    #2 rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (rf_w !== 1'b0 || fifo_cnt !== 3'd0) begin
        errors++; $display("FAIL post_reset[%0d]: got w=%0b cnt=%0d, need 0/0", i, rf_w, fifo_cnt);
      end
    end
  endtask

  task automatic test_waw();
    iss_valid = 1; iss_reg = 5'd9;
    step();
    checks++;
    if (waw_err !== 1'b0 || pend !== 32'h200) begin
      errors++; $display("FAIL waw_first: got waw=%0b pend=%h, need 0/00000200", waw_err, pend);
    end
    step();
    iss_valid = 0;
    checks++;
    if (waw_err !== 1'b1 || pend !== 32'h200) begin
      errors++; $display("FAIL waw_reissue: got waw=%0b pend=%h, need 1/00000200", waw_err, pend);
    end
    step(); step();
    checks++;
    if (waw_err !== 1'b1) begin
      errors++; $display("FAIL waw_sticky: got %0b, need 1", waw_err);
    end
  endtask

  initial begin
    test_reset();
    test_a_path();
    test_bypass_scoreboard();
    test_conflict();
    test_full_fifo();
    test_reg0();
    test_reset_mid_op();
    test_waw();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
